// File: rtl/pwm_fade_ctrl.sv
// Multi-channel PWM duty fader: one prescaled tick walks every channel's duty toward its target by a per-channel step.
// Latency: a tick seen while idle shows channel i's new duty 2+i cycles later; each channel is updated once per tick pass.
// Backpressure: cmd_ready is high only while idle; a tick that lands during a pass is remembered and starts one extra pass.
module pwm_fade_ctrl #(
  parameter int WIDTH     = 10,
  parameter int N_CH      = 3,
  parameter int DIV_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DIV_WIDTH-1:0]  cfg_div,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [3:0]            cmd_ch,
  input  logic [WIDTH-1:0]      cmd_target,
  input  logic [WIDTH-1:0]      cmd_step,
  output logic [N_CH*WIDTH-1:0] pwm_val,
  output logic [N_CH-1:0]       busy
);

  localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CH - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                      state_q;
  logic [IDX_W-1:0]            idx_q;
  logic                        pend_q;
  logic [DIV_WIDTH-1:0]        cnt_q;
  logic                        tick_q;
  logic [N_CH-1:0][WIDTH-1:0]  cur_q;
  logic [N_CH-1:0][WIDTH-1:0]  tgt_q;
  logic [N_CH-1:0][WIDTH-1:0]  step_q;

  logic                        cmd_acc;
  logic [WIDTH-1:0]            sel_cur;
  logic [WIDTH-1:0]            sel_tgt;
  logic [WIDTH-1:0]            sel_step;
  logic [WIDTH-1:0]            cur_d;
  logic [WIDTH:0]              sum_w;
  logic [WIDTH:0]              diff_w;

  assign cmd_ready = (state_q == IDLE);
  assign cmd_acc   = cmd_valid & cmd_ready;
  assign pwm_val   = cur_q;

  // A channel is busy while its duty has not yet reached its target.
  always_comb begin
    busy = '0;
    for (int i = 0; i < N_CH; i++) begin
      busy[i] = (cur_q[i] != tgt_q[i]);
    end
  end

  // Prescaler: reload on reaching cfg_div (>= so a lowered divider ticks at once) and pulse tick for one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else if (cnt_q >= cfg_div) begin
      cnt_q  <= '0;
      tick_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_q + 1'b1;
      tick_q <= 1'b0;
    end
  end

  // Pass sequencer: walk idx over all channels per tick; ticks during a pass collapse into one follow-on pass.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      pend_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (tick_q) begin
            state_q <= RUN;
            idx_q   <= '0;
            pend_q  <= 1'b0;
          end
        end
        RUN: begin
          if (idx_q == LAST_IDX) begin
            idx_q  <= '0;
            pend_q <= 1'b0;
            // A tick on the final channel cycle counts as pending too, otherwise it would be lost.
            if (!(pend_q | tick_q)) begin
              state_q <= IDLE;
            end
          end else begin
            idx_q  <= idx_q + 1'b1;
            pend_q <= pend_q | tick_q;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Select the channel addressed by idx for the shared update datapath.
  always_comb begin
    sel_cur  = '0;
    sel_tgt  = '0;
    sel_step = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (idx_q == IDX_W'(i)) begin
        sel_cur  = cur_q[i];
        sel_tgt  = tgt_q[i];
        sel_step = step_q[i];
      end
    end
  end

  // Shared adder/subtractor one bit wider than the duty so carry or borrow clamps to the target instead of wrapping.
  always_comb begin
    sum_w  = {1'b0, sel_cur} + {1'b0, sel_step};
    diff_w = {1'b0, sel_cur} - {1'b0, sel_step};
    cur_d  = sel_cur;
    if (sel_step == '0) begin
      cur_d = sel_tgt;
    end else if (sel_cur < sel_tgt) begin
      cur_d = (sum_w >= {1'b0, sel_tgt}) ? sel_tgt : sum_w[WIDTH-1:0];
    end else if (sel_cur > sel_tgt) begin
      cur_d = (diff_w[WIDTH] || (diff_w[WIDTH-1:0] <= sel_tgt)) ? sel_tgt : diff_w[WIDTH-1:0];
    end
  end

  // Per-channel state: commands load target/step only; the running pass writes the current duty of channel idx.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_q  <= '0;
      tgt_q  <= '0;
      step_q <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        // Out-of-range channel numbers match no entry and are silently dropped.
        if (cmd_acc && (cmd_ch == 4'(i))) begin
          tgt_q[i]  <= cmd_target;
          step_q[i] <= cmd_step;
        end
        if ((state_q == RUN) && (idx_q == IDX_W'(i))) begin
          cur_q[i] <= cur_d;
        end
      end
    end
  end

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// Bench for pwm_fade_ctrl: a tick-pass model checks every output each cycle, plus directed fade/clamp/reset scenarios.
// Latency: outputs are sampled on the falling edge; inputs change 1 time unit after the rising edge.
// Backpressure: commands are held until cmd_ready is seen high, within a bounded number of cycles.
module tb_pwm_fade_ctrl;

  localparam int W = 10;
  localparam int N = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [15:0]   cfg_div = 16'd3;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [3:0]    cmd_ch = '0;
  logic [W-1:0]  cmd_target = '0;
  logic [W-1:0]  cmd_step = '0;
  logic [N*W-1:0] pwm_val;
  logic [N-1:0]  busy;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  pwm_fade_ctrl #(.WIDTH(W), .N_CH(N), .DIV_WIDTH(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_div    (cfg_div),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_ch     (cmd_ch),
    .cmd_target (cmd_target),
    .cmd_step   (cmd_step),
    .pwm_val    (pwm_val),
    .busy       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_cur[N];
  int m_tgt[N];
  int m_step[N];
  int m_cnt   = 0;
  bit m_tick  = 0;
  bit m_pass  = 0;   // a tick pass is walking the channels
  int m_pos   = 0;   // channel the pass updates at the coming edge
  bit m_pend  = 0;   // a further pass has been requested

  // One fade step in plain integer arithmetic.
  function automatic int fade(input int c, input int t, input int s);
    if (s == 0) return t;
    if (c < t) return (c + s > t) ? t : c + s;
    if (c > t) return (c - s < t) ? t : c - s;
    return c;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_cur[i] = 0; m_tgt[i] = 0; m_step[i] = 0;
    end
    m_cnt = 0; m_tick = 0; m_pass = 0; m_pos = 0; m_pend = 0;
  endtask

  task automatic model_advance();
    if (cmd_valid && !m_pass && int'(cmd_ch) < N) begin
      m_tgt[cmd_ch]  = int'(cmd_target);
      m_step[cmd_ch] = int'(cmd_step);
    end
    if (m_pass) begin
      m_cur[m_pos] = fade(m_cur[m_pos], m_tgt[m_pos], m_step[m_pos]);
      if (m_pos == N - 1) begin
        m_pos = 0;
        m_pass = m_pend || m_tick;
        m_pend = 0;
      end else begin
        m_pos++;
        if (m_tick) m_pend = 1;
      end
    end else if (m_tick) begin
      m_pass = 1; m_pos = 0; m_pend = 0;
    end
    if (m_cnt >= int'(cfg_div)) begin
      m_cnt = 0; m_tick = 1;
    end else begin
      m_cnt++; m_tick = 0;
    end
  endtask

  // Compare every cycle against the model, then let the model take the coming edge.
  always @(negedge clk) begin
    logic [N*W-1:0] ev;
    logic [N-1:0]   eb;
    if (rst) model_reset();
    ev = '0;
    eb = '0;
    for (int i = 0; i < N; i++) begin
      ev[i*W +: W] = W'(m_cur[i]);
      eb[i]        = (m_cur[i] != m_tgt[i]);
    end
    chk("model_pwm_val", int'(pwm_val), int'(ev));
    chk("model_busy", int'(busy), int'(eb));
    chk("model_cmd_ready", int'(cmd_ready), int'(!m_pass));
    if (!rst) model_advance();
  end

  // ---------------- directed stimulus ----------------
  task automatic send_cmd(input int ch, input int tg, input int st);
    bit done;
    done = 0;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_ch = 4'(ch); cmd_target = W'(tg); cmd_step = W'(st);
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      if (cmd_ready) done = 1;
    end
    if (done) begin
      @(posedge clk); #1;
    end else begin
      chk("cmd_accept_timeout", 0, 1);
    end
    cmd_valid = 1'b0;
  endtask

  task automatic wait_change(input int ch, output int val, output int at);
    int  old;
    bit  seen;
    old  = int'(pwm_val[ch*W +: W]);
    seen = 0;
    val  = old;
    at   = cyc;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge clk);
      if (int'(pwm_val[ch*W +: W]) != old) begin
        seen = 1; val = int'(pwm_val[ch*W +: W]); at = cyc;
      end
    end
    if (!seen) chk("pwm_change_timeout", 0, 1);
  endtask

  initial begin
    int v, c, prev_c, rdy_cnt;
    int exp_seq[4];
    bit back;
    exp_seq = '{30, 60, 90, 100};

    // Pin the fade rule with hand-worked values.
    chk("pin_fade_up_clamp", fade(90, 100, 30), 100);
    chk("pin_fade_down", fade(1000, 5, 600), 400);
    chk("pin_fade_no_underflow", fade(400, 5, 600), 5);
    chk("pin_fade_no_overflow", fade(5, 1023, 1023), 1023);
    chk("pin_fade_jump", fade(7, 512, 0), 512);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_pwm_val", int'(pwm_val), 0);
    chk("reset_busy", int'(busy), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_cmd_ready", int'(cmd_ready), 1);

    // Ch0 fade 0 -> 100 in steps of 30, one step every 4 cycles.
    send_cmd(0, 100, 30);
    prev_c = 0;
    for (int k = 0; k < 4; k++) begin
      wait_change(0, v, c);
      chk("ch0_fade_value", v, exp_seq[k]);
      if (k > 0) chk("ch0_tick_spacing", c - prev_c, 4);
      chk("ch0_busy", int'(busy[0]), (k < 3) ? 1 : 0);
      prev_c = c;
    end

    // Ch1 clamp at both ends of the range.
    send_cmd(1, 1000, 0);
    wait_change(1, v, c);
    chk("ch1_jump_1000", v, 1000);
    send_cmd(1, 5, 600);
    wait_change(1, v, c);
    chk("ch1_down_400", v, 400);
    wait_change(1, v, c);
    chk("ch1_down_clamp_5", v, 5);
    send_cmd(1, 1023, 1023);
    wait_change(1, v, c);
    chk("ch1_up_clamp_1023", v, 1023);

    // Step 0 jump, then an out-of-range channel that must change nothing.
    send_cmd(2, 512, 0);
    wait_change(2, v, c);
    chk("ch2_jump_512", v, 512);
    send_cmd(7, 3, 3);
    repeat (12) @(negedge clk);
    chk("bad_ch_no_change_pwm", int'(pwm_val), (512 << 20) | (1023 << 10) | 100);
    chk("bad_ch_no_change_busy", int'(busy), 0);

    // cfg_div = 0: passes run back to back and commands are locked out.
    send_cmd(0, 0, 7);
    @(posedge clk); #1;
    cfg_div = 16'd0;
    repeat (6) @(negedge clk);
    rdy_cnt = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (cmd_ready) rdy_cnt++;
    end
    chk("fast_div_ready_low", rdy_cnt, 0);
    chk("ch0_down_clamp_zero", int'(pwm_val[0 +: W]), 0);
    chk("ch0_idle_busy", int'(busy[0]), 0);
    @(posedge clk); #1;
    cfg_div = 16'd20;
    back = 0;
    for (int k = 0; k < 100 && !back; k++) begin
      @(negedge clk);
      if (cmd_ready) back = 1;
    end
    chk("ready_returns", int'(back), 1);

    // Reset in the middle of a pass, right after ch0 has updated.
    @(posedge clk); #1;
    cfg_div = 16'd3;
    send_cmd(2, 0, 100);
    send_cmd(0, 300, 50);
    wait_change(0, v, c);
    chk("pre_reset_ch0", v, 50);
    #1 rst = 1'b1;
    #1;
    chk("async_reset_pwm", int'(pwm_val), 0);
    chk("async_reset_busy", int'(busy), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_reset_ready", int'(cmd_ready), 1);
    chk("post_reset_pwm", int'(pwm_val), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
